// File: rtl/cfg_discovery_rsp.sv
// Read-only configuration discovery port: returns eight 64-bit words describing the
// elaborated core, either one per request or as a sequential dump of all eight.

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVS;
        bit          RVU;
        bit          RVV;
        int unsigned IcacheByteSize;
        int unsigned DcacheByteSize;
        int unsigned IcacheSetAssoc;
        int unsigned DcacheSetAssoc;
        int unsigned IcacheLineWidth;
        int unsigned DcacheLineWidth;
        int unsigned DCacheType;
        int unsigned NrCommitPorts;
        int unsigned NrScoreboardEntries;
        int unsigned NrPMPEntries;
        int unsigned RASDepth;
        int unsigned BTBEntries;
        int unsigned BHTEntries;
        bit [63:0]   HaltAddress;
        bit [63:0]   ExceptionAddress;
        bit [63:0]   DmBaseAddress;
    } cva6_cfg_t;
endpackage

module cfg_discovery_rsp #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_t'(0),
    parameter logic [63:0]           SigVal  = 64'h4356_4136_4346_4701
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_idx_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rsp_last_o,
    input  logic        dump_i,
    output logic        dump_busy_o
);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rsp_valid_q;
    logic [63:0] rsp_data_q;
    logic        rsp_err_q;
    logic        rsp_last_q;
    logic        slot_free;
    logic        load;
    logic [63:0] load_data;
    logic        load_err;
    logic        load_last;

    // Each field is cut to its slot width; everything not written stays zero.
    function automatic logic [63:0] word_at(input logic [2:0] idx);
        logic [63:0] w;
        w = '0;
        case (idx)
            3'd0: begin
                w[0]      = CVA6Cfg.RVA;
                w[1]      = CVA6Cfg.RVB;
                w[2]      = CVA6Cfg.RVC;
                w[3]      = CVA6Cfg.RVD;
                w[5]      = CVA6Cfg.RVF;
                w[7]      = CVA6Cfg.RVH;
                w[8]      = 1'b1;
                w[12]     = 1'b1;
                w[18]     = CVA6Cfg.RVS;
                w[20]     = CVA6Cfg.RVU;
                w[21]     = CVA6Cfg.RVV;
                w[63:62]  = (CVA6Cfg.XLEN == 64) ? 2'd2 : ((CVA6Cfg.XLEN == 32) ? 2'd1 : 2'd0);
            end
            3'd1: w = {CVA6Cfg.DcacheByteSize[31:0], CVA6Cfg.IcacheByteSize[31:0]};
            3'd2: begin
                w[7:0]    = CVA6Cfg.IcacheSetAssoc[7:0];
                w[15:8]   = CVA6Cfg.DcacheSetAssoc[7:0];
                w[31:16]  = CVA6Cfg.IcacheLineWidth[15:0];
                w[47:32]  = CVA6Cfg.DcacheLineWidth[15:0];
                w[49:48]  = CVA6Cfg.DCacheType[1:0];
            end
            3'd3: begin
                w[3:0]    = CVA6Cfg.NrCommitPorts[3:0];
                w[15:8]   = CVA6Cfg.NrScoreboardEntries[7:0];
                w[23:16]  = CVA6Cfg.NrPMPEntries[7:0];
                w[31:24]  = CVA6Cfg.RASDepth[7:0];
                w[47:32]  = CVA6Cfg.BTBEntries[15:0];
                w[63:48]  = CVA6Cfg.BHTEntries[15:0];
            end
            3'd4: w = CVA6Cfg.HaltAddress;
            3'd5: w = CVA6Cfg.ExceptionAddress;
            3'd6: w = CVA6Cfg.DmBaseAddress;
            default: w = SigVal;
        endcase
        return w;
    endfunction

    assign slot_free   = !rsp_valid_q || rsp_ready_i;
    assign req_ready_o = (state_q == IDLE) && !dump_i && slot_free;
    assign dump_busy_o = (state_q == DUMP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_data = '0;
        load_err  = 1'b0;
        load_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_i) begin
                    state_d = DUMP;
                    cnt_d   = '0;
                end else if (req_valid_i && req_ready_o) begin
                    load      = 1'b1;
                    load_err  = req_idx_i[3];
                    load_data = req_idx_i[3] ? '0 : word_at(req_idx_i[2:0]);
                end
            end
            DUMP: begin
                // A response left over from IDLE drains before word 0 is loaded.
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = word_at(cnt_q);
                    load_last = (cnt_q == 3'd7);
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= load_data;
                rsp_err_q   <= load_err;
                rsp_last_q  <= load_last;
            end else if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_cfg_discovery_rsp.sv
// Scoreboarded bench for cfg_discovery_rsp: a predictor queues expected words from the
// word-map table on every accepted request or dump start, a monitor pops them on each handshake.

module tb_cfg_discovery_rsp;

    localparam logic [63:0] SIG = 64'h4356_4136_4346_4701;

    // 64-bit sv39 imafdcv core
    localparam config_pkg::cva6_cfg_t CFG = '{
        XLEN: 64, RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b0,
        RVS: 1'b1, RVU: 1'b1, RVV: 1'b1,
        IcacheByteSize: 4096, DcacheByteSize: 8192, IcacheSetAssoc: 4, DcacheSetAssoc: 8,
        IcacheLineWidth: 128, DcacheLineWidth: 128, DCacheType: 1,
        NrCommitPorts: 2, NrScoreboardEntries: 8, NrPMPEntries: 8, RASDepth: 2,
        BTBEntries: 32, BHTEntries: 128,
        HaltAddress: 64'h800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0
    };

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_idx_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rsp_last_o;
    logic        dump_i;
    logic        dump_busy_o;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails = 0;
    int          pop_count = 0;
    bit          model_in_dump = 1'b0;
    bit          prev_stall = 1'b0;
    logic [65:0] prev_rsp = '0;

    cfg_discovery_rsp #(
        .CVA6Cfg (CFG),
        .SigVal  (SIG)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_idx_i   (req_idx_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_last_o  (rsp_last_o),
        .dump_i      (dump_i),
        .dump_busy_o (dump_busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Word map of the configuration above, worked out field by field from the layout.
    function automatic exp_t ref_word(input int idx, input bit last);
        exp_t e;
        e.err  = 1'b0;
        e.last = last;
        case (idx)
            0:       e.data = 64'h8000_0000_0034_112D;
            1:       e.data = 64'h0000_2000_0000_1000;
            2:       e.data = 64'h0001_0080_0080_0804;
            3:       e.data = 64'h0080_0020_0208_0802;
            4:       e.data = 64'h0000_0000_0000_0800;
            5:       e.data = 64'h0000_0000_0000_0808;
            6:       e.data = 64'h0000_0000_0000_0000;
            7:       e.data = SIG;
            default: begin
                e.data = 64'h0;
                e.err  = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [3:0] idx, input bit ready, input bit dump);
        req_valid_i = valid;
        req_idx_i   = idx;
        rsp_ready_i = ready;
        dump_i      = dump;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic readOne(input logic [3:0] idx);
        applyStimulus(1'b1, idx, 1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("read_accept", 66'(req_ready_o), 66'(1));
        tick();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("read_latency", 66'(rsp_valid_o), 66'(1));
        tick();
    endtask

    task automatic waitDrain(input int max_cycles, input bit random_ready);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            applyStimulus(1'b0, 4'd0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("drain_pending", 66'(exp_q.size()), 66'(0));
    endtask

    // Predictor: queues what the block owes for each accepted request or started dump.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            model_in_dump = 1'b0;
        end else begin
            if (model_in_dump && exp_q.size() == 0) model_in_dump = 1'b0;
            if (dump_i && !model_in_dump) begin
                for (int i = 0; i < 8; i++) exp_q.push_back(ref_word(i, i == 7));
                model_in_dump = 1'b1;
            end else if (req_valid_i && req_ready_o) begin
                exp_q.push_back(ref_word(int'(req_idx_i), 1'b0));
            end
        end
    end

    // Monitor: compares every consumed response and holds stalled ones to their value.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && rsp_valid_o) begin
            if (prev_stall)
                checkOutput("stall_stable", {rsp_last_o, rsp_err_o, rsp_data_o}, prev_rsp);
            if (rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_rsp: got %h, expected no response", rsp_data_o);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_word", {rsp_last_o, rsp_err_o, rsp_data_o}, {e.last, e.err, e.data});
                end
                pop_count++;
            end
        end
        prev_stall = !rst_i && rsp_valid_o && !rsp_ready_i;
        prev_rsp   = {rsp_last_o, rsp_err_o, rsp_data_o};
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic [3:0] read_list [9];
        read_list = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};

        rst_i = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        tick();
        @(negedge clk_i);
        checkOutput("reset_valid", 66'(rsp_valid_o), 66'(0));
        checkOutput("reset_data", 66'(rsp_data_o), 66'(0));
        checkOutput("reset_err_last_busy", 66'({rsp_err_o, rsp_last_o, dump_busy_o}), 66'(0));
        checkOutput("reset_req_ready", 66'(req_ready_o), 66'(1));
        tick();
        rst_i = 1'b0;

        $display("[TB] single reads");
        foreach (read_list[i]) readOne(read_list[i]);
        waitDrain(10, 1'b0);

        $display("[TB] back-to-back 4,5 with 3-cycle stall");
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("b2b_accept4", 66'(req_ready_o), 66'(1));
        tick();
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("stall_req_ready", 66'(req_ready_o), 66'(0));
            checkOutput("stall_data", 66'({rsp_valid_o, rsp_data_o}), {2'b01, 64'h800});
            tick();
        end
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("stall_fourth", 66'({rsp_valid_o, rsp_data_o}), {2'b01, 64'h800});
        checkOutput("b2b_accept5", 66'(req_ready_o), 66'(1));
        tick();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("b2b_second", 66'({rsp_valid_o, rsp_data_o}), {2'b01, 64'h808});
        tick();
        waitDrain(10, 1'b0);

        $display("[TB] dump with simultaneous request");
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b1);
        @(negedge clk_i);
        checkOutput("dump_blocks_req", 66'(req_ready_o), 66'(0));
        tick();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        @(negedge clk_i);
        checkOutput("dump_busy", 66'(dump_busy_o), 66'(1));
        checkOutput("dump_req_ready", 66'(req_ready_o), 66'(0));
        tick();
        waitDrain(20, 1'b0);
        @(negedge clk_i);
        checkOutput("dump_done_idle", 66'({dump_busy_o, rsp_valid_o}), 66'(0));
        tick();

        $display("[TB] dump started behind a pending response");
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        waitDrain(30, 1'b0);

        $display("[TB] dump with random backpressure and ignored dump pulses");
        applyStimulus(1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b1);
        tick();
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'(k % 2));
            @(negedge clk_i);
            checkOutput("rand_dump_busy", 66'({dump_busy_o, req_ready_o}), 66'(2'b10));
            tick();
        end
        waitDrain(200, 1'b1);

        $display("[TB] random reads");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 99) < 60, 1'b0);
            tick();
        end
        waitDrain(20, 1'b0);

        $display("[TB] reset after third dump response");
        base = pop_count;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (pop_count >= base + 3) break;
            tick();
        end
        checkOutput("reset_point_reached", 66'(pop_count >= base + 3), 66'(1));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post_reset_idle", 66'({rsp_valid_o, dump_busy_o}), 66'(0));
        tick();
        readOne(4'd7);
        waitDrain(10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
